wb_sram_slave: RTL and testbench

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

---
 rtl/wb_sram_slave.sv | 143 ++++++++++++++
 tb/tb_wb_sram_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone classic SRAM slave with configurable wait states and byte lanes.
// Define WB_SLAVE_ERR_EN to add wb_err_o for out-of-range transfers.
module wb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o
`ifdef WB_SLAVE_ERR_EN
    ,
    output logic        wb_err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HI    = DEPTH_LOG2 + 2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:2] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];

    logic req;
    logic enter_ack;
    logic in_range_d;
    logic mem_we;
    logic [DEPTH_LOG2-1:0] idx_d;
    logic unused_addr_lsb;

    assign req             = wb_cyc_i & wb_stb_i;
    assign unused_addr_lsb = ^wb_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = wb_addr_i[31:2];
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    data_d = wb_data_i;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // addr_d/we_d/sel_d/data_d hold the transfer about to complete,
    // whether it was latched this edge (no wait states) or earlier.
    assign enter_ack  = (state_d == S_ACK) && (state_q != S_ACK);
    assign in_range_d = addr_d[31:HI] == BASE_ADDR[31:HI];
    assign idx_d      = addr_d[HI-1:2];
    assign mem_we     = enter_ack && we_d && in_range_d && !rst;

    always_comb begin
        rdata_d = '0;
        if (enter_ack && !we_d && in_range_d)
            rdata_d = mem[idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_d[b])
                    mem[idx_d][8*b +: 8] <= data_d[8*b +: 8];
            end
        end
    end

    assign wb_data_o = rdata_q;

`ifdef WB_SLAVE_ERR_EN
    logic in_range_q;
    assign in_range_q = addr_q[31:HI] == BASE_ADDR[31:HI];
    assign wb_ack_o   = (state_q == S_ACK) && in_range_q;
    assign wb_err_o   = (state_q == S_ACK) && !in_range_q;
`else
    assign wb_ack_o = (state_q == S_ACK);
`endif

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: directed cases, random traffic
// against a word-map model, and ack spacing for 0/3 wait states.
module tb_wb_sram_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          DL2  = 10;
    localparam int          WC   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic [31:0] dat1, dat0, dat3;
    logic        ack1, ack0, ack3;
    logic        err1, err0, err3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [int];

    always #5 clk = ~clk;

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
    assign err1 = 1'b0;
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    wb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) dut1 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_sel_i(sel), .wb_data_i(wdat),
        .wb_data_o(dat1), .wb_ack_o(ack1)
`ifdef WB_SLAVE_ERR_EN
        , .wb_err_o(err1)
`endif
    );

    wb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_sel_i(sel), .wb_data_i(wdat),
        .wb_data_o(dat0), .wb_ack_o(ack0)
`ifdef WB_SLAVE_ERR_EN
        , .wb_err_o(err0)
`endif
    );

    wb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_sel_i(sel), .wb_data_i(wdat),
        .wb_data_o(dat3), .wb_ack_o(ack3)
`ifdef WB_SLAVE_ERR_EN
        , .wb_err_o(err3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> (DL2 + 2)) == (BASE >> (DL2 + 2));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << DL2));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mget(input int i);
        return mdl.exists(i) ? mdl[i] : 32'h0;
    endfunction

    // Drive one request and hold it until ack/err or a 20-cycle bound.
    task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat, output bit ga, output bit ge);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdat = d;
        lat = 0; ga = 1'b0; ge = 1'b0; rd = '0;
        while (!ga && !ge && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack1) begin ga = 1'b1; rd = dat1; end
            if (err1) ge = 1'b1;
            if (ack1 && err1) check("ack_err_overlap", 32'd1, 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_width", {31'd0, ack1 | err1}, 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bit ga, ge, oor;
        xfer(1'b1, a, s, d, rd, lat, ga, ge);
        oor = !in_range(a);
        check({tag, "_ack"}, {31'd0, ga}, {31'd0, !(ERR_EN && oor)});
        check({tag, "_err"}, {31'd0, ge}, {31'd0, ERR_EN && oor});
        check({tag, "_lat"}, 32'(lat), 32'(WC + 1));
        if (!oor) mdl[widx(a)] = merge(mget(widx(a)), d, s);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           output logic [31:0] rd);
        int lat;
        bit ga, ge, oor;
        xfer(1'b0, a, 4'(($urandom)), 32'($urandom), rd, lat, ga, ge);
        oor = !in_range(a);
        check({tag, "_ack"}, {31'd0, ga}, {31'd0, !(ERR_EN && oor)});
        check({tag, "_err"}, {31'd0, ge}, {31'd0, ERR_EN && oor});
        check({tag, "_lat"}, 32'(lat), 32'(WC + 1));
        check({tag, "_data"}, rd, oor ? 32'h0 : mget(widx(a)));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int q0[$];
        int q3[$];

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; sel = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack1}, 32'd0);
        check("rst_err", {31'd0, err1}, 32'd0);
        check("rst_data", dat1, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_write("w10", 32'h10, 4'hF, 32'hDEAD_BEEF);
        do_read("r10", 32'h10, rd);
        check("r10_const", rd, 32'hDEAD_BEEF);

        do_write("pre10", 32'h10, 4'hF, 32'h1122_3344);
        do_write("lane10", 32'h10, 4'b0101, 32'hAABB_CCDD);
        do_read("rlane10", 32'h10, rd);
        check("rlane10_const", rd, 32'h11BB_33DD);

        do_write("sel0", 32'h10, 4'h0, 32'hFFFF_FFFF);
        do_read("rsel0", 32'h10, rd);

        do_write("w0", 32'h0, 4'hF, 32'hCAFE_0001);
        do_write("w20", 32'h20, 4'hF, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1;
        addr = 32'h20; sel = 4'hF; wdat = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        cyc = 1'b0;
        @(posedge clk); #1;
        check("abort_ack1", {31'd0, ack1 | err1}, 32'd0);
        stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("abort_ack2", {31'd0, ack1 | err1}, 32'd0);
        do_read("abort_rd", 32'h20, rd);
        check("abort_rd_const", rd, 32'h0);

        do_write("w30", 32'h30, 4'hF, 32'h5A5A_1234);
        cyc = 1'b1; stb = 1'b1; we = 1'b1;
        addr = 32'h30; sel = 4'hF; wdat = 32'hFFFF_0000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_ack", {31'd0, ack1 | err1}, 32'd0);
        check("rstmid_data", dat1, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("rstmid_noack", {31'd0, ack1 | err1}, 32'd0);
        end
        do_read("rstmid_rd", 32'h30, rd);
        check("rstmid_rd_const", rd, 32'h5A5A_1234);

        do_write("oor_w", 32'h0000_1000, 4'hF, 32'h1234_5678);
        do_read("oor_r", 32'h0000_1000, rd);
        check("oor_r_const", rd, 32'h0);
        do_read("oor_alias", 32'h0, rd);
        check("oor_alias_const", rd, 32'hCAFE_0001);

        for (int i = 0; i < 16; i++)
            do_write("pool", 32'(i * 4), 4'hF, 32'($urandom));
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write("rnd_w", a, 4'($urandom), 32'($urandom));
            else
                do_read("rnd_r", a, rd);
        end

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
        for (int t = 1; t <= 24; t++) begin
            @(posedge clk); #1;
            if (ack0) q0.push_back(t);
            if (ack3) q3.push_back(t);
        end
        cyc = 1'b0; stb = 1'b0;
        check("w0_count", 32'(q0.size()), 32'd12);
        check("w3_count", 32'(q3.size()), 32'd5);
        if (q0.size() > 0) check("w0_first", 32'(q0[0]), 32'd1);
        if (q3.size() > 0) check("w3_first", 32'(q3[0]), 32'd4);
        for (int i = 1; i < q0.size(); i++)
            check("w0_spacing", 32'(q0[i] - q0[i-1]), 32'd2);
        for (int i = 1; i < q3.size(); i++)
            check("w3_spacing", 32'(q3[i] - q3[i-1]), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
